// File: rtl/tlx_rdata_pkg.sv
// Shared definitions for the TLX response-data buffer: rd_cnt decode,
// error-bit positions and default widths.
package tlx_rdata_pkg;

  localparam int DEFAULT_DATA_W   = 512;
  localparam int DEFAULT_CREDIT_W = 7;

  localparam int ERR_PEND_OVF = 0;
  localparam int ERR_CRD_UNF  = 1;
  localparam int ERR_CRD_OVF  = 2;
  localparam int ERR_W        = 3;

  typedef logic [ERR_W-1:0] err_vec_t;

  // The 3-bit beat-count field encodes 8 as zero.
  function automatic logic [3:0] decode_rd_cnt(input logic [2:0] cnt);
    return (cnt == 3'b000) ? 4'd8 : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/tlx_sync_fifo.sv
// Single-clock FIFO with registered read port and a registered fill level.
module tlx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_V = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level_reg == DEPTH_V);
  assign empty   = (level_reg == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign level   = level_reg;
  assign rd_data = rd_data_reg;

  // Storage array kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        rd_data_reg <= mem[rd_ptr_reg];
      end
      if (do_wr && !do_rd) begin
        level_reg <= level_reg + LW'(1);
      end else if (do_rd && !do_wr) begin
        level_reg <= level_reg - LW'(1);
      end
    end
  end

endmodule

// File: rtl/tlx_afu_resp_data_buf.sv
// TLX response-data buffer and AFU response-credit tracker.
// Optional TLX_RDATA_BDI_EN carries a bad-data bit alongside each beat.
module tlx_afu_resp_data_buf
  import tlx_rdata_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = 16,
  parameter int MAX_PEND = 32,
  parameter int CREDIT_W = DEFAULT_CREDIT_W
) (
  input  logic                    clock_tlx,
  input  logic                    reset_n,
  input  logic                    bfm_push_valid,
  input  logic [DATA_W-1:0]       bfm_push_data,
  input  logic                    bfm_push_bdi,
  output logic                    bfm_push_ready,
  input  logic                    afu_tlx_resp_rd_req,
  input  logic [2:0]              afu_tlx_resp_rd_cnt,
  output logic                    tlx_afu_resp_data_valid,
  output logic [DATA_W-1:0]       tlx_afu_resp_data_bus,
  output logic                    tlx_afu_resp_data_bdi,
  input  logic                    init_credit_load,
  input  logic [CREDIT_W-1:0]     afu_tlx_resp_initial_credit,
  input  logic                    afu_tlx_resp_credit,
  input  logic                    resp_credit_consume,
  output logic [CREDIT_W-1:0]     resp_credit_avail,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [2:0]              err_sticky
);

`ifdef TLX_RDATA_BDI_EN
  localparam int FIFO_W = DATA_W + 1;
`else
  localparam int FIFO_W = DATA_W;
`endif
  localparam int PEND_W = $clog2(MAX_PEND + 8) + 1;
  localparam logic [PEND_W-1:0] MAX_PEND_V = PEND_W'(MAX_PEND);

  logic [FIFO_W-1:0]   fifo_wr_data;
  logic [FIFO_W-1:0]   fifo_rd_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic [PEND_W-1:0]   pend_cnt_reg;
  logic [PEND_W-1:0]   pend_cnt_next;
  logic [PEND_W-1:0]   req_beats;
  logic [PEND_W-1:0]   pend_sum;
  logic                req_drop;
  logic                req_accept;
  logic                pop;
  logic                data_valid_reg;
  logic [CREDIT_W-1:0] credit_reg;
  logic [CREDIT_W-1:0] credit_next;
  logic [CREDIT_W-1:0] init_max_reg;
  err_vec_t            err_reg;
  err_vec_t            err_next;

`ifdef TLX_RDATA_BDI_EN
  assign fifo_wr_data          = {bfm_push_bdi, bfm_push_data};
  assign tlx_afu_resp_data_bdi = data_valid_reg && fifo_rd_data[DATA_W];
`else
  logic unused_bdi;
  assign unused_bdi            = bfm_push_bdi;
  assign fifo_wr_data          = bfm_push_data;
  assign tlx_afu_resp_data_bdi = 1'b0;
`endif

  tlx_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock_tlx),
    .rst_n   (reset_n),
    .wr_en   (bfm_push_valid),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bfm_push_ready          = !fifo_full;
  assign tlx_afu_resp_data_valid = data_valid_reg;
  assign tlx_afu_resp_data_bus   = fifo_rd_data[DATA_W-1:0];
  assign resp_credit_avail       = credit_reg;
  assign err_sticky              = err_reg;

  assign req_beats  = afu_tlx_resp_rd_req ? PEND_W'(decode_rd_cnt(afu_tlx_resp_rd_cnt)) : '0;
  assign pend_sum   = pend_cnt_reg + req_beats;
  assign req_drop   = afu_tlx_resp_rd_req && (pend_sum > MAX_PEND_V);
  assign req_accept = afu_tlx_resp_rd_req && !req_drop;
  // A fresh request may pop in its own cycle so the first beat lands one cycle later.
  assign pop        = !fifo_empty && ((pend_cnt_reg != '0) || req_accept);

  always_comb begin
    pend_cnt_next = pend_cnt_reg;
    if (req_accept) begin
      pend_cnt_next = pend_sum;
    end
    if (pop) begin
      pend_cnt_next = pend_cnt_next - PEND_W'(1);
    end
  end

  always_comb begin
    credit_next = credit_reg;
    err_next    = err_reg;
    if (init_credit_load) begin
      credit_next = afu_tlx_resp_initial_credit;
    end else if (afu_tlx_resp_credit && !resp_credit_consume) begin
      if (credit_reg >= init_max_reg) begin
        err_next[ERR_CRD_OVF] = 1'b1;
      end else begin
        credit_next = credit_reg + CREDIT_W'(1);
      end
    end else if (resp_credit_consume && !afu_tlx_resp_credit) begin
      if (credit_reg == '0) begin
        err_next[ERR_CRD_UNF] = 1'b1;
      end else begin
        credit_next = credit_reg - CREDIT_W'(1);
      end
    end
    if (req_drop) begin
      err_next[ERR_PEND_OVF] = 1'b1;
    end
  end

  always_ff @(posedge clock_tlx or negedge reset_n) begin
    if (!reset_n) begin
      pend_cnt_reg   <= '0;
      data_valid_reg <= 1'b0;
      credit_reg     <= '0;
      init_max_reg   <= '0;
      err_reg        <= '0;
    end else begin
      pend_cnt_reg   <= pend_cnt_next;
      data_valid_reg <= pop;
      credit_reg     <= credit_next;
      err_reg        <= err_next;
      if (init_credit_load) begin
        init_max_reg <= afu_tlx_resp_initial_credit;
      end
    end
  end

endmodule
